serial_cipher_engine: RTL and testbench

- Line-buffered byte cipher that sits between `rxuart` and `txuart`.
- Collects received bytes into a RAM line buffer until a terminator run of TERM_LEN × TERM_CHAR arrives.
- Then streams the buffered payload, with the terminator stripped, through a per-byte cipher to the transmitter.
- Successor to the fixed 1024-byte encrypter. Adds:
  - parametrised depth and terminator
  - encrypt/decrypt mode and optional rolling key
  - overflow reporting
  - sequential per-byte ciphering instead of a full-buffer combinational array

---
 rtl/serial_cipher_engine.sv | 174 +++++++++++++++++
 tb/tb_serial_cipher_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cipher_engine.sv
// Line-buffered byte cipher between a UART receiver and transmitter: buffers a line
// until a run of TERM_LEN x TERM_CHAR, then ciphers and sends the payload one byte at a time.
module serial_cipher_engine #(
    parameter int         AW        = 10,
    parameter logic [7:0] TERM_CHAR = 8'h31,
    parameter int         TERM_LEN  = 3,
    parameter int         LW        = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_rx_stb,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_err,
    input  logic [7:0]    i_key,
    input  logic [7:0]    i_offset,
    input  logic          i_decrypt,
    input  logic          i_rolling,
    input  logic          i_tx_busy,
    output logic          o_tx_stb,
    output logic [7:0]    o_tx_data,
    output logic          o_busy,
    output logic          o_overflow,
    output logic [LW-1:0] o_line_len
);
    localparam int DEPTH = 2 ** AW;
    localparam int TW    = AW + 4;
    localparam logic [TW-1:0] DEPTH_T    = TW'(DEPTH);
    localparam logic [TW-1:0] TOTAL_MAX  = TW'(DEPTH + TERM_LEN);
    localparam logic [2:0]    MATCH_LAST = 3'(TERM_LEN - 1);

    typedef enum logic [1:0] {S_FILL, S_FETCH, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]   total_q, total_d;
    logic [2:0]      match_q, match_d;
    logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   line_len_q, line_len_d;
    logic [7:0]      key_q, key_d, off_q, off_d, key_cur_q, key_cur_d;
    logic            dec_q, dec_d, roll_q, roll_d;
    logic            tx_stb_q, tx_stb_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic [7:0]      mem [DEPTH];
    logic            rx_acc, term_hit, mem_we;
    logic [TW-1:0]   len_full, len_clip;
    logic [7:0]      rd_byte, cipher_byte;

    always_comb begin
        rx_acc      = i_rx_stb && !i_rx_err && (state_q == S_FILL);
        term_hit    = rx_acc && (i_rx_data == TERM_CHAR) && (match_q == MATCH_LAST);
        mem_we      = rx_acc && (total_q < DEPTH_T);
        len_full    = total_q + TW'(1) - TW'(TERM_LEN);
        len_clip    = (len_full > DEPTH_T) ? DEPTH_T : len_full;
        rd_byte     = mem[rd_ptr_q[AW-1:0]];
        cipher_byte = dec_q ? ((rd_byte ^ key_cur_q) - off_q) : ((rd_byte + off_q) ^ key_cur_q);

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        total_d    = total_q;
        match_d    = match_q;
        rd_ptr_d   = rd_ptr_q;
        line_len_d = line_len_q;
        key_d      = key_q;
        off_d      = off_q;
        key_cur_d  = key_cur_q;
        dec_d      = dec_q;
        roll_d     = roll_q;
        tx_stb_d   = tx_stb_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_FILL: begin
                if (rx_acc) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    total_d  = (total_q == TOTAL_MAX) ? total_q : total_q + TW'(1);
                    match_d  = (i_rx_data == TERM_CHAR) ? match_q + 3'd1 : 3'd0;
                    // The first byte of a line clears the sticky flag from the previous line.
                    if (total_q == '0)
                        ovf_d = 1'b0;
                    else if (total_q >= DEPTH_T)
                        ovf_d = 1'b1;
                end
                if (term_hit) begin
                    line_len_d = len_clip[LW-1:0];
                    key_d      = i_key;
                    off_d      = i_offset;
                    dec_d      = i_decrypt;
                    roll_d     = i_rolling;
                    key_cur_d  = i_key;
                    match_d    = '0;
                    wr_ptr_d   = '0;
                    total_d    = '0;
                    rd_ptr_d   = '0;
                    if (len_clip != '0) begin
                        state_d = S_FETCH;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                tx_data_d = cipher_byte;
                tx_stb_d  = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (!i_tx_busy) begin
                    tx_stb_d = 1'b0;
                    rd_ptr_d = rd_ptr_q + LW'(1);
                    if (roll_q)
                        key_cur_d = {key_cur_q[6:0], key_cur_q[7]};
                    if (rd_ptr_q == line_len_q - LW'(1)) begin
                        state_d = S_FILL;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_FILL;
            wr_ptr_q   <= '0;
            total_q    <= '0;
            match_q    <= '0;
            rd_ptr_q   <= '0;
            line_len_q <= '0;
            key_q      <= '0;
            off_q      <= '0;
            key_cur_q  <= '0;
            dec_q      <= 1'b0;
            roll_q     <= 1'b0;
            tx_stb_q   <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            total_q    <= total_d;
            match_q    <= match_d;
            rd_ptr_q   <= rd_ptr_d;
            line_len_q <= line_len_d;
            key_q      <= key_d;
            off_q      <= off_d;
            key_cur_q  <= key_cur_d;
            dec_q      <= dec_d;
            roll_q     <= roll_d;
            tx_stb_q   <= tx_stb_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    // Line storage has no reset; only locations below the latched length are ever read.
    always_ff @(posedge i_clk) begin
        if (mem_we)
            mem[wr_ptr_q] <= i_rx_data;
    end

    assign o_tx_stb   = tx_stb_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;
    assign o_line_len = line_len_q;

endmodule

// File: tb/tb_serial_cipher_engine.sv
// Directed bench for serial_cipher_engine: a default-depth instance and a 4-byte instance
// share all inputs; transmitted bytes are collected and compared against hand-computed values.
module tb_serial_cipher_engine;
  logic clk = 1'b0;
  logic rst;
  logic rx_stb, rx_err, dec, roll, tx_busy;
  logic [7:0] rx_data, key, off;

  logic tx_stb, busy, ovf;
  logic [7:0] tx_data;
  logic [10:0] line_len;
  logic tx_stb_s, busy_s, ovf_s;
  logic [7:0] tx_data_s;
  logic [2:0] line_len_s;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got_s_q[$];
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_cipher_engine u_dut (
    .i_clk(clk), .i_reset(rst), .i_rx_stb(rx_stb), .i_rx_data(rx_data), .i_rx_err(rx_err),
    .i_key(key), .i_offset(off), .i_decrypt(dec), .i_rolling(roll), .i_tx_busy(tx_busy),
    .o_tx_stb(tx_stb), .o_tx_data(tx_data), .o_busy(busy), .o_overflow(ovf),
    .o_line_len(line_len)
  );

  serial_cipher_engine #(.AW(2)) u_small (
    .i_clk(clk), .i_reset(rst), .i_rx_stb(rx_stb), .i_rx_data(rx_data), .i_rx_err(rx_err),
    .i_key(key), .i_offset(off), .i_decrypt(dec), .i_rolling(roll), .i_tx_busy(tx_busy),
    .o_tx_stb(tx_stb_s), .o_tx_data(tx_data_s), .o_busy(busy_s), .o_overflow(ovf_s),
    .o_line_len(line_len_s)
  );

  // Handshake: a byte is taken by the transmitter in any cycle with o_tx_stb && !i_tx_busy.
  always @(negedge clk) begin
    if (tx_stb && !tx_busy) got_q.push_back(tx_data);
    if (tx_stb_s && !tx_busy) got_s_q.push_back(tx_data_s);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want below 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input logic [7:0] k, input logic [7:0] o, input logic d, input logic r);
    @(posedge clk); #1;
    key = k; off = o; dec = d; roll = r;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(posedge clk); #1;
    rx_stb = 1'b1; rx_data = b; rx_err = err;
    @(posedge clk); #1;
    rx_stb = 1'b0; rx_err = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((busy || busy_s) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL drain_timeout: busy=%0b busy_s=%0b want 0 within 2000 cycles", busy, busy_s);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); got_s_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_stb = 1'b0; rx_data = 8'h00; rx_err = 1'b0;
    key = 8'h00; off = 8'h00; dec = 1'b0; roll = 1'b0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_stb, tx_data, busy, ovf, line_len} !== 22'd0) begin
      fails++;
      $display("FAIL reset_outputs: got stb=%0b data=%h busy=%0b ovf=%0b len=%0d want all 0",
               tx_stb, tx_data, busy, ovf, line_len);
    end
    checks++;
    if ({tx_stb_s, tx_data_s, busy_s, ovf_s, line_len_s} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs_small: got stb=%0b data=%h busy=%0b ovf=%0b len=%0d want all 0",
               tx_stb_s, tx_data_s, busy_s, ovf_s, line_len_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_encrypt();
    clear_q();
    set_cfg(8'h5A, 8'h03, 1'b0, 1'b0);
    send_line("AB111");
    wait_drain();
    exp_q = '{8'h1E, 8'h1F};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL enc_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL enc_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (line_len !== 11'd2) begin
      fails++;
      $display("FAIL enc_line_len: got %0d want 2", line_len);
    end
  endtask

  task automatic test_decrypt();
    clear_q();
    set_cfg(8'h5A, 8'h03, 1'b1, 1'b0);
    send_byte(8'h1E, 1'b0);
    send_byte(8'h1F, 1'b0);
    send_line("111");
    wait_drain();
    exp_q = '{8'h41, 8'h42};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL dec_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL dec_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rolling();
    clear_q();
    set_cfg(8'h5A, 8'h03, 1'b0, 1'b1);
    send_line("AB111");
    wait_drain();
    exp_q = '{8'h1E, 8'hF1};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL roll_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL roll_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_terminators();
    clear_q();
    set_cfg(8'h5A, 8'h03, 1'b0, 1'b0);
    send_line("11X111");
    wait_drain();
    exp_q = '{8'h6E, 8'h6E, 8'h01};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL embed_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL embed_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (line_len !== 11'd3) begin
      fails++;
      $display("FAIL embed_line_len: got %0d want 3", line_len);
    end
    clear_q();
    send_line("111");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx_stb !== 1'b0) begin
        fails++;
        $display("FAIL empty_idle c%0d: got busy=%0b stb=%0b want 0 0", i, busy, tx_stb);
      end
    end
    checks++;
    if (line_len !== 11'd0 || got_q.size() != 0) begin
      fails++;
      $display("FAIL empty_line: got len=%0d bytes=%0d want 0 0", line_len, got_q.size());
    end
  endtask

  task automatic test_overflow();
    clear_q();
    set_cfg(8'h5A, 8'h03, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 1'b0);
    send_line("111");
    wait_drain();
    exp_q = '{8'h49, 8'h4E, 8'h4F, 8'h4C};
    checks++;
    if (got_s_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL ovf_count: got %0d bytes want %0d", got_s_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_s_q.size()) begin
      checks++;
      if (got_s_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ovf_byte%0d: got %h want %h", i, got_s_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ovf_s !== 1'b1 || line_len_s !== 3'd4) begin
      fails++;
      $display("FAIL ovf_flag_small: got ovf=%0b len=%0d want 1 4", ovf_s, line_len_s);
    end
    checks++;
    if (ovf !== 1'b0 || line_len !== 11'd6 || got_q.size() != 6) begin
      fails++;
      $display("FAIL ovf_flag_big: got ovf=%0b len=%0d bytes=%0d want 0 6 6",
               ovf, line_len, got_q.size());
    end
    clear_q();
    send_byte("A", 1'b0);
    @(negedge clk);
    checks++;
    if (ovf_s !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %0b want 0", ovf_s);
    end
    send_line("111");
    wait_drain();
    checks++;
    if (got_s_q.size() != 1 || got_s_q[0] !== 8'h1E) begin
      fails++;
      $display("FAIL ovf_next_line: got %0d bytes first=%h want 1 byte 1e",
               got_s_q.size(), (got_s_q.size() > 0) ? got_s_q[0] : 8'h00);
    end
  endtask

  task automatic test_busy_hold();
    int n = 0;
    clear_q();
    set_cfg(8'h5A, 8'h03, 1'b0, 1'b0);
    tx_busy = 1'b1;
    send_line("A111");
    @(negedge clk);
    while (!tx_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    send_byte("Z", 1'b0);
    key = 8'hFF; off = 8'h77;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (tx_stb !== 1'b1 || tx_data !== 8'h1E) begin
        fails++;
        $display("FAIL busy_hold c%0d: got stb=%0b data=%h want 1 1e", i, tx_stb, tx_data);
      end
    end
    @(posedge clk); #1;
    tx_busy = 1'b0;
    wait_drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h1E) begin
      fails++;
      $display("FAIL busy_release: got %0d bytes first=%h want 1 byte 1e",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_rx_error();
    clear_q();
    set_cfg(8'h5A, 8'h03, 1'b0, 1'b0);
    send_byte("C", 1'b1);
    send_byte("D", 1'b0);
    send_byte("1", 1'b1);
    send_byte("1", 1'b0);
    send_byte("1", 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL err_match: got busy=%0b want 0 after two good terminators", busy);
    end
    send_byte("1", 1'b0);
    wait_drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h1D || line_len !== 11'd1) begin
      fails++;
      $display("FAIL err_line: got %0d bytes first=%h len=%0d want 1 byte 1d len 1",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, line_len);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    clear_q();
    set_cfg(8'h5A, 8'h03, 1'b0, 1'b0);
    tx_busy = 1'b1;
    send_line("AB111");
    @(negedge clk);
    while (!tx_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_stb, tx_data, busy, ovf, line_len} !== 22'd0) begin
      fails++;
      $display("FAIL reset_mid_drain: got stb=%0b data=%h busy=%0b ovf=%0b len=%0d want all 0",
               tx_stb, tx_data, busy, ovf, line_len);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_busy = 1'b0;
    send_line("A111");
    wait_drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h1E) begin
      fails++;
      $display("FAIL reset_discard: got %0d bytes first=%h want 1 byte 1e",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_rolling();
    test_terminators();
    test_overflow();
    test_busy_hold();
    test_rx_error();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
